// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges load returns and ALU results onto one register
// file write port, tracks outstanding loads for decode hazard detection.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  input  logic [4:0]  q_rd,
  output logic        hazard,
  output logic [4:0]  rd,
  output logic [31:0] rrd,
  output logic        we
);

  logic [31:0] r_pending;
  logic        r_skid_valid;
  logic [4:0]  r_skid_rd;
  logic [31:0] r_skid_data;
  logic [4:0]  r_rd;
  logic [31:0] r_rrd;
  logic        r_we;

  logic        w_sel;
  logic        w_sel_skid;
  logic [4:0]  w_sel_rd;
  logic [31:0] w_sel_data;
  logic        w_skid_load;
  logic [31:0] w_pend_nxt;
  logic        w_hz_rs1;
  logic        w_hz_rs2;
  logic        w_hz_rd;

  assign alu_ready = ~r_skid_valid;

  // Load return always wins; skid drains before any new ALU result.
  always_comb begin
    w_sel      = 1'b0;
    w_sel_skid = 1'b0;
    w_sel_rd   = 5'd0;
    w_sel_data = 32'd0;
    priority case (1'b1)
      mem_valid: begin
        w_sel      = 1'b1;
        w_sel_rd   = mem_rd;
        w_sel_data = mem_data;
      end
      r_skid_valid: begin
        w_sel      = 1'b1;
        w_sel_skid = 1'b1;
        w_sel_rd   = r_skid_rd;
        w_sel_data = r_skid_data;
      end
      alu_valid: begin
        w_sel      = 1'b1;
        w_sel_rd   = alu_rd;
        w_sel_data = alu_data;
      end
      default: ;
    endcase
  end

  assign w_skid_load = alu_valid & alu_ready & mem_valid;

  // A load issued in the same cycle as a return to that reg stays pending.
  always_comb begin
    w_pend_nxt = r_pending;
    if (mem_valid)
      w_pend_nxt[mem_rd] = 1'b0;
    if (ld_issue && ld_issue_rd != 5'd0)
      w_pend_nxt[ld_issue_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  assign w_hz_rs1 = (q_rs1 != 5'd0) & r_pending[q_rs1];
  assign w_hz_rs2 = (q_rs2 != 5'd0) & r_pending[q_rs2];
  assign w_hz_rd  = (q_rd  != 5'd0) & r_pending[q_rd];
  assign hazard   = w_hz_rs1 | w_hz_rs2 | w_hz_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending    <= 32'd0;
      r_skid_valid <= 1'b0;
      r_skid_rd    <= 5'd0;
      r_skid_data  <= 32'd0;
      r_we         <= 1'b0;
      r_rd         <= 5'd0;
      r_rrd        <= 32'd0;
    end else begin
      r_pending <= w_pend_nxt;
      if (w_skid_load) begin
        r_skid_valid <= 1'b1;
        r_skid_rd    <= alu_rd;
        r_skid_data  <= alu_data;
      end else if (w_sel_skid) begin
        r_skid_valid <= 1'b0;
      end
      r_we <= w_sel & (w_sel_rd != 5'd0);
      if (w_sel && w_sel_rd != 5'd0) begin
        r_rd  <= w_sel_rd;
        r_rrd <= w_sel_data;
      end
    end
  end

  assign rd  = r_rd;
  assign rrd = r_rrd;
  assign we  = r_we;

endmodule

// File: tb/tb_wb_arbiter.sv
// Vector table and scoreboard bench for the writeback arbiter.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic [4:0]  q_rd;
  logic        hazard;
  logic [4:0]  rd;
  logic [31:0] rrd;
  logic        we;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
    .hazard(hazard), .rd(rd), .rrd(rrd), .we(we)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        li;
    logic [4:0]  lrd;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic [4:0]  q3;
    logic        ery;
    logic        ehz;
    logic        ewe;
    logic [4:0]  erd;
    logic [31:0] errd;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rrd;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic li, input logic [4:0] lrd,
    input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] q3,
    input logic ery, input logic ehz,
    input logic ewe, input logic [4:0] erd, input logic [31:0] errd);
    vec_t t;
    t.av = av; t.ard = ard; t.ad = ad;
    t.mv = mv; t.mrd = mrd; t.md = md;
    t.li = li; t.lrd = lrd;
    t.q1 = q1; t.q2 = q2; t.q3 = q3;
    t.ery = ery; t.ehz = ehz;
    t.ewe = ewe; t.erd = erd; t.errd = errd;
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    alu_valid   = t.av;  alu_rd = t.ard; alu_data = t.ad;
    mem_valid   = t.mv;  mem_rd = t.mrd; mem_data = t.md;
    ld_issue    = t.li;  ld_issue_rd = t.lrd;
    q_rs1 = t.q1; q_rs2 = t.q2; q_rd = t.q3;
  endtask

  task automatic pop_check(input string tag);
    wr_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " we"}, {31'd0, we}, {31'd0, e.we});
      chk({tag, " rd"}, {27'd0, rd}, {27'd0, e.rd});
      chk({tag, " rrd"}, rrd, e.rrd);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    wr_t e;
    drive(t);
    e.we = t.ewe; e.rd = t.erd; e.rrd = t.errd;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, " alu_ready"}, {31'd0, alu_ready}, {31'd0, t.ery});
    chk({tag, " hazard"}, {31'd0, hazard}, {31'd0, t.ehz});
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    wr_t  e;
    idle = '{default: '0};
    rst = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    chk("reset we", {31'd0, we}, 32'd0);
    chk("reset rd", {27'd0, rd}, 32'd0);
    chk("reset rrd", rrd, 32'd0);
    rst = 1'b0;

    //  av ard adata  mv mrd mdata  li lrd q1 q2 q3 rdy hz  we rd rrd
    v(1, 5, 32'h1234, 0, 0, 0,     0, 0,  0, 0, 0,  1, 0,  1, 5, 32'h1234);
    v(0, 0, 0,        0, 0, 0,     0, 0,  0, 0, 0,  1, 0,  0, 5, 32'h1234);
    v(1, 3, 32'hAA,   1, 7, 32'hBB,0, 0,  0, 0, 0,  1, 0,  1, 7, 32'hBB);
    v(0, 0, 0,        0, 0, 0,     0, 0,  0, 0, 0,  0, 0,  1, 3, 32'hAA);
    v(0, 0, 0,        0, 0, 0,     0, 0,  0, 0, 0,  1, 0,  0, 3, 32'hAA);
    v(0, 0, 0,        0, 0, 0,     1, 9,  0, 9, 0,  1, 0,  0, 3, 32'hAA);
    v(0, 0, 0,        0, 0, 0,     0, 0,  0, 9, 0,  1, 1,  0, 3, 32'hAA);
    v(0, 0, 0,        1, 9, 32'h99,0, 0,  0, 9, 0,  1, 1,  1, 9, 32'h99);
    v(0, 0, 0,        0, 0, 0,     0, 0,  0, 9, 0,  1, 0,  0, 9, 32'h99);
    v(0, 0, 0,        1, 4, 32'h44,1, 4,  4, 0, 0,  1, 0,  1, 4, 32'h44);
    v(0, 0, 0,        0, 0, 0,     0, 0,  4, 0, 0,  1, 1,  0, 4, 32'h44);
    v(0, 0, 0,        1, 4, 32'h4, 0, 0,  4, 0, 0,  1, 1,  1, 4, 32'h4);
    v(0, 0, 0,        0, 0, 0,     0, 0,  4, 0, 0,  1, 0,  0, 4, 32'h4);
    v(1, 0, 32'hFFFF_FFFF, 0, 0, 0,0, 0,  0, 0, 0,  1, 0,  0, 4, 32'h4);
    v(0, 0, 0,        0, 0, 0,     1, 0,  0, 0, 0,  1, 0,  0, 4, 32'h4);
    v(0, 0, 0,        0, 0, 0,     0, 0,  0, 0, 0,  1, 0,  0, 4, 32'h4);
    v(1, 6, 32'h66,   1, 0, 32'h55,0, 0,  0, 0, 0,  1, 0,  0, 4, 32'h4);
    v(0, 0, 0,        0, 0, 0,     0, 0,  0, 0, 0,  0, 0,  1, 6, 32'h66);
    v(1, 8, 32'h88,   0, 0, 0,     0, 0,  0, 0, 0,  1, 0,  1, 8, 32'h88);
    v(0, 0, 0,        1,10, 32'hA0,1,12,  0, 0, 0,  1, 0,  1,10, 32'hA0);
    v(0, 0, 0,        0, 0, 0,     0, 0,  0, 0,12,  1, 1,  0,10, 32'hA0);
    v(0, 0, 0,        1,12, 32'hC, 0, 0,  0, 0,12,  1, 1,  1,12, 32'hC);
    v(0, 0, 0,        0, 0, 0,     0, 0,  0, 0,12,  1, 0,  0,12, 32'hC);
    // Skid stays full while further load returns keep winning.
    v(1, 1, 32'h11,   1, 2, 32'h22,0, 0,  0, 0, 0,  1, 0,  1, 2, 32'h22);
    v(1, 5, 32'h55,   1, 3, 32'h33,0, 0,  0, 0, 0,  0, 0,  1, 3, 32'h33);
    v(0, 0, 0,        0, 0, 0,     0, 0,  0, 0, 0,  0, 0,  1, 1, 32'h11);
    v(0, 0, 0,        0, 0, 0,     0, 0,  0, 0, 0,  1, 0,  0, 1, 32'h11);
    // Fill skid and mark x14 pending ahead of the reset sequence.
    v(1,11, 32'hDEAD, 1,13, 32'hBEEF,1,14, 0, 0, 0, 1, 0,  1,13, 32'hBEEF);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset with a full skid and active inputs that must all be ignored.
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd15; alu_data = 32'hF00D;
    mem_valid = 1'b1; mem_rd = 5'd16; mem_data = 32'hCAFE;
    ld_issue = 1'b1; ld_issue_rd = 5'd17;
    @(negedge clk);
    chk("rst skid_full ready", {31'd0, alu_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst we", {31'd0, we}, 32'd0);
    chk("rst rd", {27'd0, rd}, 32'd0);
    chk("rst rrd", rrd, 32'd0);
    idle.q1 = 5'd14; idle.q2 = 5'd17; idle.q3 = 5'd16;
    idle.ery = 1'b1; idle.ehz = 1'b0;
    idle.ewe = 1'b0; idle.erd = 5'd0; idle.errd = 32'd0;
    for (int k = 0; k < 4; k++) apply(idle, $sformatf("post_rst%0d", k));

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // A stale skid write of 0xDEAD would surface here at any time.
  always @(negedge clk) begin
    if (!rst && we && rrd == 32'hDEAD) begin
      failures++;
      $display("FAIL skid_after_reset: got write rd=%0d rrd=%0h expected none",
               rd, rrd);
    end
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on posedge clk.
REQ-002 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: alu_valid  in  1  ALU result available this cycle.
REQ-004 SHALL have ports: alu_rd  in  5  ALU destination register.
REQ-005 SHALL have ports: alu_data  in  32  ALU result.
REQ-006 SHALL have ports: alu_ready  out  1  ALU result accepted this cycle when high together with alu_valid.
REQ-007 SHALL have ports: mem_valid  in  1  load data returned this cycle; always accepted, no ready.
REQ-008 SHALL have ports: mem_rd  in  5  load destination register.
REQ-009 SHALL have ports: mem_data  in  32  load data.
REQ-010 SHALL have ports: ld_issue  in  1  decode issued a load this cycle.
REQ-011 SHALL have ports: ld_issue_rd  in  5  destination of the issued load.
REQ-012 SHALL have ports: q_rs1, q_rs2, q_rd  in  5 each  decode-stage hazard query registers.
REQ-013 SHALL have ports: hazard  out  1  combinational stall request to decode.
REQ-014 SHALL have ports: rd  out  5, rrd  out  32, we  out  1  registered write port driving the register file.

Function
REQ-015 SHALL hold a 32-bit pending vector; bit n set means a load to xn is outstanding; bit 0 never set.
REQ-016 SHALL set pending[ld_issue_rd] on a cycle with ld_issue=1 and ld_issue_rd!=0.
REQ-017 SHALL clear pending[mem_rd] on a cycle with mem_valid=1.
REQ-018 SHALL give set priority over clear when both target the same bit in one cycle.
REQ-019 SHALL drive hazard=1 iff pending[q_rs1] | pending[q_rs2] | pending[q_rd], with index 0 always reading 0; pure function of current state and query inputs.
REQ-020 SHALL hold a 1-entry skid buffer (skid_valid, skid_rd, skid_data) for ALU results.
REQ-021 SHALL drive alu_ready = ~skid_valid (combinational).
REQ-022 SHALL select the writeback source each cycle, priority mem > skid > ALU: mem_valid wins; else skid if skid_valid; else the ALU handshake.
REQ-023 SHALL capture the ALU result into skid when alu_valid&alu_ready and mem_valid=1 in the same cycle.
REQ-024 SHALL empty skid in any cycle where skid is selected; a new ALU result cannot arrive that cycle because alu_ready=0.
REQ-025 SHALL register the selected (rd, data) into rd/rrd one cycle after selection; latency input->we is exactly 1 cycle.
REQ-026 SHALL drive we=1 only when a source was selected and its rd!=0; otherwise we=0, rd and rrd hold their previous values.
REQ-027 SHALL treat mem_valid with a non-pending mem_rd as a legal write; the clear is a no-op.
REQ-028 SHALL never lose or reorder results; the skid result writes no earlier than the mem result that displaced it.

Reset
REQ-029 SHALL on rst=1 at posedge clear pending to 0, skid_valid to 0, and we to 0, and set rd=0 and rrd=0.
REQ-030 SHALL discard in-flight skid contents on reset mid-operation; the inputs of the reset cycle are ignored.
REQ-031 SHALL hold alu_ready=1 and hazard=0 combinationally in the first cycle after reset.

Verification
REQ-032 SHALL be tested with: alu_valid, alu_rd=5, alu_data=0x1234 -> next cycle we=1, rd=5, rrd=0x1234.
REQ-033 SHALL be tested with: alu (rd=3, 0xAA) and mem (rd=7, 0xBB) valid in the same cycle -> cycle+1 shows we rd=7 0xBB and alu_ready=0 -> cycle+2 shows we rd=3 0xAA and alu_ready=1.
REQ-034 SHALL be tested with: ld_issue rd=9, then q_rs2=9 -> hazard=1 until the cycle after mem_valid rd=9, then hazard=0.
REQ-035 SHALL be tested with: ld_issue rd=4 and mem_valid rd=4 in the same cycle -> pending[4] stays 1 and hazard=1 for q_rs1=4.
REQ-036 SHALL be tested with: alu_valid rd=0 data=0xFFFF_FFFF -> we stays 0; ld_issue rd=0 -> hazard stays 0 for q_rs1=0.
REQ-037 SHALL be tested with: skid full, then rst=1 for one cycle -> next cycle we=0, alu_ready=1, and no write of the skid value ever appears.
